// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the RAM arbiter
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rtl/ram_arbiter_rr_pick2.sv - combinational two-way requester picker
module ram_arbiter_rr_pick2
   import ram_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   input  logic rr_mode,
   output logic winner,
   output logic any_req
);

   // A lone request wins; a tie goes to the other side in round-robin mode, else to requester 0
   always_comb begin
      any_req = req0 | req1;
      winner  = 1'b0;
      if (req0 && req1) begin
         winner = rr_mode ? ~last_grant : 1'b0;
      end else if (req1) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - serialises two requesters onto one single-port synchronous RAM
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int RR     = 1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              req0,
   input  logic              rwN0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              rwN1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_readWriteN,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_out,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              busy
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              ram_rwn_q, ram_rwn_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_dout_q, ram_dout_d;
   logic              busy_q, busy_d;
   logic              winner;
   logic              any_req;

   ram_arbiter_rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant_q),
      .rr_mode    (RR != 0),
      .winner     (winner),
      .any_req    (any_req)
   );

   // State and output registers; last_grant also identifies the owner of the transaction in flight
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ram_rwn_q    <= RW_READ;
         ram_addr_q   <= '0;
         ram_dout_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ram_rwn_q    <= ram_rwn_d;
         ram_addr_q   <= ram_addr_d;
         ram_dout_q   <= ram_dout_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and next-output logic: grants and read-valids are single-cycle pulses
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ram_rwn_d    = ram_rwn_q;
      ram_addr_d   = ram_addr_q;
      ram_dout_d   = ram_dout_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               ram_addr_d   = winner ? addr1  : addr0;
               ram_rwn_d    = winner ? rwN1   : rwN0;
               ram_dout_d   = winner ? wdata1 : wdata0;
               gnt0_d       = ~winner;
               gnt1_d       = winner;
               last_grant_d = winner;
               busy_d       = 1'b1;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            // The RAM samples address/mode/data at the edge that closes this state
            ram_rwn_d = RW_READ;
            if (ram_rwn_q == RW_READ) begin
               state_d = RESP;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         RESP: begin
            if (last_grant_q) begin
               rdata1_d  = ram_data_in;
               rvalid1_d = 1'b1;
            end else begin
               rdata0_d  = ram_data_in;
               rvalid0_d = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign gnt0           = gnt0_q;
   assign gnt1           = gnt1_q;
   assign rvalid0        = rvalid0_q;
   assign rvalid1        = rvalid1_q;
   assign rdata0         = rdata0_q;
   assign rdata1         = rdata1_q;
   assign ram_readWriteN = ram_rwn_q;
   assign ram_address    = ram_addr_q;
   assign ram_data_out   = ram_dout_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter in round-robin and fixed-priority modes
module tb_ram_arbiter;

   logic       clk;
   logic       resetN;
   logic       req0, rwN0, req1, rwN1;
   logic [7:0] addr0, wdata0, addr1, wdata1;

   logic       a_gnt0, a_gnt1, a_rv0, a_rv1, a_rwn, a_busy;
   logic [7:0] a_rd0, a_rd1, a_addr, a_dout, a_din;
   logic       b_gnt0, b_gnt1, b_rv0, b_rv1, b_rwn, b_busy;
   logic [7:0] b_rd0, b_rd1, b_addr, b_dout, b_din;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic       bd_we;
   logic [7:0] bd_addr, bd_data;

   int n_cmp = 0;
   int n_bad = 0;

   ram_arbiter #(.DATA_W(8), .ADDR_W(8), .RR(1)) dut_a (
      .clk(clk), .resetN(resetN),
      .req0(req0), .rwN0(rwN0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
      .req1(req1), .rwN1(rwN1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
      .ram_readWriteN(a_rwn), .ram_address(a_addr), .ram_data_out(a_dout),
      .ram_data_in(a_din), .busy(a_busy)
   );

   ram_arbiter #(.DATA_W(8), .ADDR_W(8), .RR(0)) dut_b (
      .clk(clk), .resetN(resetN),
      .req0(req0), .rwN0(rwN0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
      .req1(req1), .rwN1(rwN1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
      .ram_readWriteN(b_rwn), .ram_address(b_addr), .ram_data_out(b_dout),
      .ram_data_in(b_din), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM models with a backdoor load port
   always @(posedge clk) begin
      if (bd_we) begin
         mem_a[bd_addr] <= bd_data;
         mem_b[bd_addr] <= bd_data;
      end else begin
         if (a_rwn == 1'b0) mem_a[a_addr] <= a_dout;
         if (b_rwn == 1'b0) mem_b[b_addr] <= b_dout;
      end
      a_din <= mem_a[a_addr];
      b_din <= mem_b[b_addr];
   end

   typedef struct {
      logic       rstn;
      logic       q0;
      logic       rw0;
      logic [7:0] ad0;
      logic [7:0] wd0;
      logic       q1;
      logic       rw1;
      logic [7:0] ad1;
      logic [7:0] wd1;
      logic       e_g0;
      logic       e_g1;
      logic       e_v0;
      logic       e_v1;
      logic [7:0] e_d0;
      logic [7:0] e_d1;
      logic       e_rwn;
      logic [7:0] e_addr;
      logic [7:0] e_dout;
      logic       e_busy;
   } vec_t;

   vec_t vec [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic reset_pulse();
      resetN = 1'b0;
      @(posedge clk); #1;
      resetN = 1'b1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; rwN0 = 1'b1; addr0 = 8'h00; wdata0 = 8'h00;
      req1 = 1'b0; rwN1 = 1'b1; addr1 = 8'h00; wdata1 = 8'h00;
   endtask

   initial begin
      logic [37:0] exp_bus;
      int          na, nb, coll, gap_ok;
      logic [3:0]  ord_a, ord_b;

      bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
      resetN = 1'b0;
      idle_inputs();
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      @(posedge clk); #1;
      preload(8'h10, 8'hA5);
      preload(8'h30, 8'h11);
      preload(8'h31, 8'h22);

      //          rst q0 rw0 ad0    wd0    q1 rw1 ad1    wd1    g0 g1 v0 v1 d0     d1     rwn addr   dout   busy
      vec[0]  = '{0,  0, 1,  8'h00, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1,  8'h00, 8'h00, 0};
      vec[1]  = '{1,  1, 1,  8'h10, 8'h00, 0, 1,  8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 1,  8'h10, 8'h00, 1};
      vec[2]  = '{1,  0, 1,  8'h10, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1,  8'h10, 8'h00, 1};
      vec[3]  = '{1,  0, 1,  8'h10, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h00, 1,  8'h10, 8'h00, 0};
      vec[4]  = '{1,  0, 1,  8'h10, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00, 1,  8'h10, 8'h00, 0};
      vec[5]  = '{1,  0, 1,  8'h00, 8'h00, 1, 0,  8'h20, 8'h3C, 0, 1, 0, 0, 8'hA5, 8'h00, 0,  8'h20, 8'h3C, 1};
      vec[6]  = '{1,  0, 1,  8'h00, 8'h00, 0, 0,  8'h20, 8'h3C, 0, 0, 0, 0, 8'hA5, 8'h00, 1,  8'h20, 8'h3C, 0};
      vec[7]  = '{1,  1, 1,  8'h20, 8'h00, 0, 1,  8'h00, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h00, 1,  8'h20, 8'h00, 1};
      vec[8]  = '{1,  0, 1,  8'h20, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00, 1,  8'h20, 8'h00, 1};
      vec[9]  = '{1,  0, 1,  8'h20, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 1, 0, 8'h3C, 8'h00, 1,  8'h20, 8'h00, 0};
      vec[10] = '{1,  0, 1,  8'h20, 8'h00, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 8'h3C, 8'h00, 1,  8'h20, 8'h00, 0};
      vec[11] = '{1,  0, 1,  8'h00, 8'h00, 1, 1,  8'h10, 8'h00, 0, 1, 0, 0, 8'h3C, 8'h00, 1,  8'h10, 8'h00, 1};
      vec[12] = '{1,  0, 1,  8'h00, 8'h00, 0, 1,  8'h10, 8'h00, 0, 0, 0, 0, 8'h3C, 8'h00, 1,  8'h10, 8'h00, 1};
      vec[13] = '{1,  0, 1,  8'h00, 8'h00, 0, 1,  8'h10, 8'h00, 0, 0, 0, 1, 8'h3C, 8'hA5, 1,  8'h10, 8'h00, 0};

      // Single read, single write, read-back and a requester-1 read; no ties so both modes agree
      for (int i = 0; i < 14; i++) begin
         resetN = vec[i].rstn;
         req0 = vec[i].q0; rwN0 = vec[i].rw0; addr0 = vec[i].ad0; wdata0 = vec[i].wd0;
         req1 = vec[i].q1; rwN1 = vec[i].rw1; addr1 = vec[i].ad1; wdata1 = vec[i].wd1;
         @(posedge clk); #1;
         exp_bus = {vec[i].e_g0, vec[i].e_g1, vec[i].e_v0, vec[i].e_v1, vec[i].e_d0, vec[i].e_d1,
                    vec[i].e_rwn, vec[i].e_addr, vec[i].e_dout, vec[i].e_busy};
         check($sformatf("vecA%0d", i),
               {26'd0, a_gnt0, a_gnt1, a_rv0, a_rv1, a_rd0, a_rd1, a_rwn, a_addr, a_dout, a_busy},
               {26'd0, exp_bus});
         check($sformatf("vecB%0d", i),
               {26'd0, b_gnt0, b_gnt1, b_rv0, b_rv1, b_rd0, b_rd1, b_rwn, b_addr, b_dout, b_busy},
               {26'd0, exp_bus});
      end
      check("ram_0x20_written", {56'd0, mem_a[8'h20]}, 64'h3C);

      // Both requesters hold continuous read requests: RR alternates, fixed priority starves requester 1
      idle_inputs();
      reset_pulse();
      req0 = 1'b1; addr0 = 8'h30; req1 = 1'b1; addr1 = 8'h31;
      na = 0; nb = 0; coll = 0; ord_a = 4'h0; ord_b = 4'h0;
      for (int c = 0; c < 40 && na < 4; c++) begin
         @(posedge clk); #1;
         if ((a_gnt0 && a_gnt1) || (a_rv0 && a_rv1) || (b_gnt0 && b_gnt1) || (b_rv0 && b_rv1)) coll++;
         if (b_gnt0 || b_gnt1) begin
            if (nb < 4) ord_b[nb] = b_gnt1;
            nb++;
         end
         if (a_gnt0 || a_gnt1) begin
            ord_a[na] = a_gnt1;
            na++;
            if (na == 4) begin
               req0 = 1'b0; req1 = 1'b0;
            end
         end
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if ((a_gnt0 && a_gnt1) || (a_rv0 && a_rv1) || (b_gnt0 && b_gnt1) || (b_rv0 && b_rv1)) coll++;
      end
      check("rr_grant_count", 64'(na), 64'd4);
      check("rr_grant_order", {60'd0, ord_a}, {60'd0, 4'b1010});
      check("fixed_grant_count", 64'(nb), 64'd4);
      check("fixed_grant_order", {60'd0, ord_b}, 64'd0);
      check("no_collisions", 64'(coll), 64'd0);
      check("rr_rdata", {48'd0, a_rd0, a_rd1}, {48'd0, 16'h1122});

      // Fixed priority: requester 1 is served on the IDLE edge right after requester 0 lets go
      idle_inputs();
      reset_pulse();
      req0 = 1'b1; addr0 = 8'h30; req1 = 1'b1; addr1 = 8'h31;
      na = 0;
      for (int c = 0; c < 10 && na == 0; c++) begin
         @(posedge clk); #1;
         if (b_gnt0) na = 1;
      end
      check("fixed_first_gnt0", 64'(na), 64'd1);
      req0 = 1'b0;
      gap_ok = 1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (b_gnt1) gap_ok = 0;
      end
      @(posedge clk); #1;
      check("fixed_gnt1_after_drop", {62'd0, b_gnt1, gap_ok[0]}, 64'd3);
      req1 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
      end

      // Reset during RESP drops the pending read response
      idle_inputs();
      req0 = 1'b1; rwN0 = 1'b1; addr0 = 8'h10;
      @(posedge clk); #1;
      check("rst_resp_gnt0", {63'd0, a_gnt0}, 64'd1);
      req0 = 1'b0;
      @(posedge clk); #1;
      check("rst_resp_in_resp", {62'd0, a_busy, a_rv0}, 64'd2);
      resetN = 1'b0;
      @(posedge clk); #1;
      check("rst_resp_outputs",
            {26'd0, a_gnt0, a_gnt1, a_rv0, a_rv1, a_rd0, a_rd1, a_rwn, a_addr, a_dout, a_busy},
            {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0});
      resetN = 1'b1;
      @(posedge clk); #1;
      check("rst_resp_no_rvalid", {62'd0, a_rv0, a_busy}, 64'd0);

      // Reset on the closing edge of a write ACCESS still commits the write
      req0 = 1'b1; rwN0 = 1'b0; addr0 = 8'h05; wdata0 = 8'h77;
      @(posedge clk); #1;
      check("rst_wr_access", {55'd0, a_rwn, a_addr}, {55'd0, 1'b0, 8'h05});
      req0 = 1'b0; rwN0 = 1'b1;
      resetN = 1'b0;
      @(posedge clk); #1;
      check("rst_wr_committed", {56'd0, mem_a[8'h05]}, 64'h77);
      check("rst_wr_outputs", {62'd0, a_rwn, a_busy}, 64'd2);
      resetN = 1'b1;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
